// File: rtl/regwr_arbiter.sv
// Two-requester write arbiter for a shared register-bank write port.
// Round-robin between requesters, with per-requester lock to keep the grant across beats.
module regwr_arbiter #(
    parameter int WIDTH  = 32,
    parameter int ADDR_W = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              hold,
    input  logic              req0_valid,
    input  logic              req0_lock,
    input  logic [ADDR_W-1:0] req0_addr,
    input  logic [WIDTH-1:0]  req0_data,
    output logic              req0_ready,
    input  logic              req1_valid,
    input  logic              req1_lock,
    input  logic [ADDR_W-1:0] req1_addr,
    input  logic [WIDTH-1:0]  req1_data,
    output logic              req1_ready,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [WIDTH-1:0]  wr_data,
    output logic              owner
);
    typedef enum logic [1:0] {IDLE, LOCK0, LOCK1} state_e;

    state_e            state_q, state_d;
    logic              prio_q, prio_d;
    logic              gnt0, gnt1, acc, sel, sel_lock;
    logic              wr_en_q, owner_q;
    logic [ADDR_W-1:0] wr_addr_q;
    logic [WIDTH-1:0]  wr_data_q;

    // Readies depend on rst directly so they drop the moment reset asserts.
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (rst && !hold) begin
            case (state_q)
                IDLE: begin
                    if (req0_valid && req1_valid) begin
                        gnt0 = !prio_q;
                        gnt1 = prio_q;
                    end else begin
                        gnt0 = req0_valid;
                        gnt1 = req1_valid;
                    end
                end
                LOCK0:   gnt0 = req0_valid;
                LOCK1:   gnt1 = req1_valid;
                default: ;
            endcase
        end
    end

    assign req0_ready = gnt0;
    assign req1_ready = gnt1;
    assign acc        = gnt0 | gnt1;
    assign sel        = gnt1;
    assign sel_lock   = sel ? req1_lock : req0_lock;

    // Priority passes to the other side on every accept except a lock continuation.
    always_comb begin
        state_d = state_q;
        prio_d  = prio_q;
        if (acc) begin
            state_d = sel_lock ? (sel ? LOCK1 : LOCK0) : IDLE;
            if (state_q == IDLE || !sel_lock)
                prio_d = ~sel;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            prio_q    <= 1'b0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            owner_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            prio_q  <= prio_d;
            wr_en_q <= acc;
            if (acc) begin
                wr_addr_q <= sel ? req1_addr : req0_addr;
                wr_data_q <= sel ? req1_data : req0_data;
                owner_q   <= sel;
            end
        end
    end

    assign wr_en   = wr_en_q;
    assign wr_addr = wr_addr_q;
    assign wr_data = wr_data_q;
    assign owner   = owner_q;
endmodule
